// File: rtl/bcd_rx_frame.sv
// Frame receiver for the HO/IM1/IM0 serial link: filters the synchronised pins,
// assembles WORD_W-bit words and reports strobe, short-frame and timeout errors.
module bcd_rx_frame #(
    parameter int WORD_W    = 16,
    parameter int WORDS     = 95,
    parameter int FILT      = 6,
    parameter int MSB_FIRST = 0,
    parameter int TMO       = 4095
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              HO,
    input  logic              IM1,
    input  logic              IM0,
    output logic [WORD_W-1:0] oData,
    output logic              oVal,
    output logic [7:0]        oWordIdx,
    output logic              oFrameStart,
    output logic              oFrameDone,
    output logic              oErr,
    output logic [1:0]        oErrCode
);
    localparam int TW = $clog2(TMO + 1);
    localparam int BW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, HO_WAIT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]        filt_q, filt_d, ho_filt_q, ho_filt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              bit_q, bit_d;
    logic [WORD_W-1:0] shift_q, shift_d, data_q, data_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]        word_cnt_q, word_cnt_d, idx_q, idx_d;
    logic              val_q, val_d, start_q, start_d, done_q, done_d, err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic              ho, im1, im0, in_bit, cond, accept, ho_low_acc, tmo_hit, raise;
    logic [1:0]        raise_code;
    logic [WORD_W-1:0] next_word;

    assign ho         = sync2_q[2];
    assign im1        = sync2_q[1];
    assign im0        = sync2_q[0];
    assign in_bit     = (state_q == BIT_HI) || (state_q == BIT_LO);
    assign accept     = cond && (filt_q == 4'(FILT - 1));
    assign ho_low_acc = in_bit && !ho && (ho_filt_q == 4'(FILT - 1));
    assign tmo_hit    = in_bit && (tmo_q == TW'(TMO - 1));
    assign next_word  = (MSB_FIRST != 0) ? {shift_q[WORD_W-2:0], bit_q}
                                         : {bit_q, shift_q[WORD_W-1:1]};

    // The level each state is waiting for; the shared filter counts it.
    always_comb begin
        cond = 1'b0;
        case (state_q)
            IDLE:    cond = ho;
            BIT_HI:  cond = im1 || im0;
            BIT_LO:  cond = !im1 && !im0;
            HO_WAIT: cond = !ho;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        sync1_d    = {HO, IM1, IM0};
        sync2_d    = sync1_q;
        state_d    = state_q;
        filt_d     = cond ? filt_q + 4'd1 : 4'd0;
        ho_filt_d  = (in_bit && !ho) ? ho_filt_q + 4'd1 : 4'd0;
        tmo_d      = in_bit ? tmo_q + 1'b1 : '0;
        bit_d      = bit_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        data_d     = data_q;
        idx_d      = idx_q;
        val_d      = 1'b0;
        start_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        code_d     = code_q;
        raise      = 1'b0;
        raise_code = 2'b00;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    start_d    = 1'b1;
                    err_d      = 1'b0;
                    code_d     = 2'b00;
                    bit_cnt_d  = '0;
                    word_cnt_d = 8'd0;
                    shift_d    = '0;
                    state_d    = BIT_HI;
                end
            end
            BIT_HI: begin
                if (im1 && im0) begin
                    raise      = 1'b1;
                    raise_code = 2'b01;
                    state_d    = HO_WAIT;
                end else if (ho_low_acc) begin
                    raise      = 1'b1;
                    raise_code = 2'b10;
                    state_d    = IDLE;
                end else if (tmo_hit) begin
                    raise      = 1'b1;
                    raise_code = 2'b11;
                    state_d    = HO_WAIT;
                end else if (accept) begin
                    bit_d   = im1;
                    state_d = BIT_LO;
                end
            end
            BIT_LO: begin
                if (ho_low_acc) begin
                    raise      = 1'b1;
                    raise_code = 2'b10;
                    state_d    = IDLE;
                end else if (tmo_hit) begin
                    raise      = 1'b1;
                    raise_code = 2'b11;
                    state_d    = HO_WAIT;
                end else if (accept) begin
                    shift_d = next_word;
                    state_d = BIT_HI;
                    if (bit_cnt_q == BW'(WORD_W - 1)) begin
                        bit_cnt_d  = '0;
                        data_d     = next_word;
                        idx_d      = word_cnt_q;
                        val_d      = 1'b1;
                        word_cnt_d = word_cnt_q + 8'd1;
                        if (word_cnt_q == 8'(WORDS - 1)) begin
                            done_d  = 1'b1;
                            state_d = HO_WAIT;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            HO_WAIT: begin
                if (accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Only the first error of a frame is kept until the next frame start.
        if (raise && !err_q) begin
            err_d  = 1'b1;
            code_d = raise_code;
        end
        if (state_d != state_q) begin
            filt_d = 4'd0;
            tmo_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q    <= IDLE;
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            filt_q     <= 4'd0;
            ho_filt_q  <= 4'd0;
            tmo_q      <= '0;
            bit_q      <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= 8'd0;
            data_q     <= '0;
            idx_q      <= 8'd0;
            val_q      <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            ho_filt_q  <= ho_filt_d;
            tmo_q      <= tmo_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            start_q    <= start_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign oData       = data_q;
    assign oVal        = val_q;
    assign oWordIdx    = idx_q;
    assign oFrameStart = start_q;
    assign oFrameDone  = done_q;
    assign oErr        = err_q;
    assign oErrCode    = code_q;
endmodule

// File: tb/tb_bcd_rx_frame.sv
// Bench for bcd_rx_frame: an LSB-first and an MSB-first receiver share the same pins
// and are checked against words rebuilt from the bits the bench sent.
module tb_bcd_rx_frame;
    localparam int WORD_W = 16;
    localparam int WORDS  = 4;
    localparam int FILT   = 6;
    localparam int TMO    = 100;

    logic clk = 1'b0;
    logic nRST, HO, IM1, IM0;

    logic [WORD_W-1:0] a_data, b_data;
    logic [7:0]        a_idx, b_idx;
    logic              a_val, a_start, a_done, a_err, b_val, b_start, b_done, b_err;
    logic [1:0]        a_code, b_code;
    logic [29:0]       a_all, b_all;

    assign a_all = {a_data, a_val, a_idx, a_start, a_done, a_err, a_code};
    assign b_all = {b_data, b_val, b_idx, b_start, b_done, b_err, b_code};

    bcd_rx_frame #(.WORD_W(WORD_W), .WORDS(WORDS), .FILT(FILT), .MSB_FIRST(0), .TMO(TMO)) dut_lsb (
        .clk(clk), .nRST(nRST), .HO(HO), .IM1(IM1), .IM0(IM0),
        .oData(a_data), .oVal(a_val), .oWordIdx(a_idx), .oFrameStart(a_start),
        .oFrameDone(a_done), .oErr(a_err), .oErrCode(a_code)
    );

    bcd_rx_frame #(.WORD_W(WORD_W), .WORDS(WORDS), .FILT(FILT), .MSB_FIRST(1), .TMO(TMO)) dut_msb (
        .clk(clk), .nRST(nRST), .HO(HO), .IM1(IM1), .IM0(IM0),
        .oData(b_data), .oVal(b_val), .oWordIdx(b_idx), .oFrameStart(b_start),
        .oFrameDone(b_done), .oErr(b_err), .oErrCode(b_code)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Everything each receiver delivered since the last frame start.
    logic [WORD_W-1:0] a_data_q[$], b_data_q[$];
    logic [7:0]        a_idx_q[$], b_idx_q[$];
    bit                a_done_q[$], b_done_q[$];
    bit                sent_bits[$];
    int                a_starts = 0, b_starts = 0, pulse_viol = 0, orphan_done = 0;
    logic              a_val_p = 1'b0, b_val_p = 1'b0, a_start_p = 1'b0, b_start_p = 1'b0;

    always @(negedge clk) begin
        if (a_val === 1'b1) begin
            a_data_q.push_back(a_data); a_idx_q.push_back(a_idx); a_done_q.push_back(a_done);
        end
        if (b_val === 1'b1) begin
            b_data_q.push_back(b_data); b_idx_q.push_back(b_idx); b_done_q.push_back(b_done);
        end
        if (a_start === 1'b1) a_starts++;
        if (b_start === 1'b1) b_starts++;
        if ((a_done === 1'b1 && a_val !== 1'b1) || (b_done === 1'b1 && b_val !== 1'b1)) orphan_done++;
        if ((a_val === 1'b1 && a_val_p === 1'b1) || (b_val === 1'b1 && b_val_p === 1'b1) ||
            (a_start === 1'b1 && a_start_p === 1'b1) || (b_start === 1'b1 && b_start_p === 1'b1))
            pulse_viol++;
        a_val_p = a_val; b_val_p = b_val; a_start_p = a_start; b_start_p = b_start;
    end

    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: word w is the weighted sum of its WORD_W received bits.
    function automatic logic [WORD_W-1:0] exp_word(int w, bit msb);
        int unsigned v = 0;
        for (int i = 0; i < WORD_W; i++)
            if (sent_bits[w * WORD_W + i]) v += msb ? (32'd1 << (WORD_W - 1 - i)) : (32'd1 << i);
        return WORD_W'(v);
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(bit b, int hi, int lo, bit glitch, bit dropout);
        IM1 = b; IM0 = !b;
        if (dropout) begin
            tick(3); HO = 1'b0; tick(4); HO = 1'b1; tick(hi - 7);
        end else begin
            tick(hi);
        end
        IM1 = 1'b0; IM0 = 1'b0;
        tick(lo);
        if (glitch) begin
            IM1 = 1'b1; tick(3); IM1 = 1'b0; tick(5);
        end
        sent_bits.push_back(b);
    endtask

    task automatic send_bits(int n, bit rnd_bits, bit rnd_len, bit glitchy);
        for (int i = 0; i < n; i++) begin
            bit b;
            int hi, lo;
            b  = rnd_bits ? 1'($urandom_range(0, 1)) : (i % 2 == 0);
            hi = rnd_len ? int'($urandom_range(8, 14)) : 10;
            lo = rnd_len ? int'($urandom_range(8, 14)) : 10;
            send_bit(b, hi, lo, glitchy && (i % 3 == 1), glitchy && (i % 5 == 2));
        end
    endtask

    task automatic start_frame();
        a_data_q.delete(); a_idx_q.delete(); a_done_q.delete();
        b_data_q.delete(); b_idx_q.delete(); b_done_q.delete();
        sent_bits.delete();
        HO = 1'b1;
        tick(12);
    endtask

    task automatic end_frame();
        HO = 1'b0;
        tick(15);
    endtask

    task automatic test_reset();
        tick(4);
        checks++;
        if (a_all !== '0 || b_all !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got lsb=%h msb=%h expected 0", a_all, b_all);
        end
        nRST = 1'b1;
        tick(3);
        checks++;
        if (a_all !== '0 || b_all !== '0) begin
            failures++;
            $display("[TB] FAIL idle_outputs got lsb=%h msb=%h expected 0", a_all, b_all);
        end
    endtask

    task automatic test_alternating();
        int sa = a_starts, sb = b_starts;
        start_frame();
        send_bits(64, 1'b0, 1'b0, 1'b0);
        end_frame();
        checks++;
        if (a_starts != sa + 1 || b_starts != sb + 1) begin
            failures++;
            $display("[TB] FAIL alt_starts got lsb=%0d msb=%0d expected 1", a_starts - sa, b_starts - sb);
        end
        checks++;
        if (a_data_q.size() != 4 || b_data_q.size() != 4) begin
            failures++;
            $display("[TB] FAIL alt_words got lsb=%0d msb=%0d expected 4", a_data_q.size(), b_data_q.size());
        end
        for (int w = 0; w < 4 && w < a_data_q.size() && w < b_data_q.size(); w++) begin
            checks++;
            if ({a_data_q[w], a_idx_q[w], a_done_q[w], b_data_q[w], b_idx_q[w], b_done_q[w]} !==
                {16'h5555, 8'(w), w == 3, 16'hAAAA, 8'(w), w == 3}) begin
                failures++;
                $display("[TB] FAIL alt_word%0d got lsb=%h/%0d/%0b msb=%h/%0d/%0b expected 5555/AAAA idx %0d done %0b",
                         w, a_data_q[w], a_idx_q[w], a_done_q[w], b_data_q[w], b_idx_q[w], b_done_q[w], w, w == 3);
            end
        end
        checks++;
        if ({a_err, a_code, b_err, b_code} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL alt_err got lsb=%0b/%b msb=%0b/%b expected 0/00", a_err, a_code, b_err, b_code);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            start_frame();
            send_bits(64, 1'b1, 1'b1, 1'b0);
            end_frame();
            checks++;
            if (a_data_q.size() != WORDS || b_data_q.size() != WORDS) begin
                failures++;
                $display("[TB] FAIL rnd_words frame %0d got lsb=%0d msb=%0d expected %0d",
                         f, a_data_q.size(), b_data_q.size(), WORDS);
            end
            for (int w = 0; w < WORDS && w < a_data_q.size() && w < b_data_q.size(); w++) begin
                checks++;
                if ({a_data_q[w], a_idx_q[w], a_done_q[w], b_data_q[w], b_idx_q[w], b_done_q[w]} !==
                    {exp_word(w, 1'b0), 8'(w), w == WORDS - 1, exp_word(w, 1'b1), 8'(w), w == WORDS - 1}) begin
                    failures++;
                    $display("[TB] FAIL rnd_word%0d got lsb=%h/%0d/%0b msb=%h/%0d/%0b expected %h/%h idx %0d",
                             w, a_data_q[w], a_idx_q[w], a_done_q[w], b_data_q[w], b_idx_q[w], b_done_q[w],
                             exp_word(w, 1'b0), exp_word(w, 1'b1), w);
                end
            end
            checks++;
            if (a_err !== 1'b0 || b_err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rnd_err got lsb=%0b msb=%0b expected 0", a_err, b_err);
            end
        end
    endtask

    task automatic test_glitches();
        start_frame();
        send_bits(64, 1'b0, 1'b0, 1'b1);
        end_frame();
        checks++;
        if (a_data_q.size() != 4 || b_data_q.size() != 4) begin
            failures++;
            $display("[TB] FAIL glitch_words got lsb=%0d msb=%0d expected 4", a_data_q.size(), b_data_q.size());
        end
        for (int w = 0; w < 4 && w < a_data_q.size() && w < b_data_q.size(); w++) begin
            checks++;
            if ({a_data_q[w], a_idx_q[w], b_data_q[w], b_idx_q[w]} !== {16'h5555, 8'(w), 16'hAAAA, 8'(w)}) begin
                failures++;
                $display("[TB] FAIL glitch_word%0d got lsb=%h/%0d msb=%h/%0d expected 5555/AAAA idx %0d",
                         w, a_data_q[w], a_idx_q[w], b_data_q[w], b_idx_q[w], w);
            end
        end
        checks++;
        if (a_err !== 1'b0 || b_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL glitch_err got lsb=%0b msb=%0b expected 0", a_err, b_err);
        end
    endtask

    task automatic test_both_high();
        start_frame();
        send_bits(20, 1'b1, 1'b0, 1'b0);
        IM1 = 1'b1; IM0 = 1'b1;
        tick(10);
        IM1 = 1'b0; IM0 = 1'b0;
        tick(10);
        send_bits(10, 1'b1, 1'b0, 1'b0);
        end_frame();
        checks++;
        if (a_data_q.size() != 1 || b_data_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL both_words got lsb=%0d msb=%0d expected 1", a_data_q.size(), b_data_q.size());
        end else begin
            checks++;
            if ({a_data_q[0], a_idx_q[0], a_done_q[0], b_data_q[0], b_done_q[0]} !==
                {exp_word(0, 1'b0), 8'd0, 1'b0, exp_word(0, 1'b1), 1'b0}) begin
                failures++;
                $display("[TB] FAIL both_word0 got lsb=%h/%0d/%0b msb=%h/%0b expected %h/0/0 %h/0",
                         a_data_q[0], a_idx_q[0], a_done_q[0], b_data_q[0], b_done_q[0],
                         exp_word(0, 1'b0), exp_word(0, 1'b1));
            end
        end
        checks++;
        if ({a_err, a_code, b_err, b_code} !== 6'b101_101) begin
            failures++;
            $display("[TB] FAIL both_err got lsb=%0b/%b msb=%0b/%b expected 1/01", a_err, a_code, b_err, b_code);
        end
        start_frame();
        send_bits(64, 1'b1, 1'b1, 1'b0);
        end_frame();
        checks++;
        if (a_data_q.size() != WORDS || a_err !== 1'b0 || b_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL both_rearm got words=%0d err=%0b/%0b expected %0d words err 0",
                     a_data_q.size(), a_err, b_err, WORDS);
        end
    endtask

    task automatic test_short_frame();
        int sa = a_starts;
        start_frame();
        send_bits(40, 1'b1, 1'b1, 1'b0);
        end_frame();
        checks++;
        if (a_data_q.size() != 2 || b_data_q.size() != 2) begin
            failures++;
            $display("[TB] FAIL short_words got lsb=%0d msb=%0d expected 2", a_data_q.size(), b_data_q.size());
        end
        for (int w = 0; w < 2 && w < a_data_q.size() && w < b_data_q.size(); w++) begin
            checks++;
            if ({a_data_q[w], a_idx_q[w], a_done_q[w], b_data_q[w], b_done_q[w]} !==
                {exp_word(w, 1'b0), 8'(w), 1'b0, exp_word(w, 1'b1), 1'b0}) begin
                failures++;
                $display("[TB] FAIL short_word%0d got lsb=%h/%0d/%0b msb=%h/%0b expected %h/%0d/0 %h/0",
                         w, a_data_q[w], a_idx_q[w], a_done_q[w], b_data_q[w], b_done_q[w],
                         exp_word(w, 1'b0), w, exp_word(w, 1'b1));
            end
        end
        checks++;
        if ({a_err, a_code, b_err, b_code} !== 6'b110_110) begin
            failures++;
            $display("[TB] FAIL short_err got lsb=%0b/%b msb=%0b/%b expected 1/10", a_err, a_code, b_err, b_code);
        end
        start_frame();
        checks++;
        if ({a_err, a_code, b_err, b_code} !== 6'b0 || a_starts != sa + 2) begin
            failures++;
            $display("[TB] FAIL short_clear got lsb=%0b/%b msb=%0b/%b starts=%0d expected 0/00 starts=2",
                     a_err, a_code, b_err, b_code, a_starts - sa);
        end
        send_bits(64, 1'b1, 1'b1, 1'b0);
        end_frame();
        checks++;
        if (a_data_q.size() != WORDS || b_data_q.size() != WORDS) begin
            failures++;
            $display("[TB] FAIL short_next got lsb=%0d msb=%0d expected %0d", a_data_q.size(), b_data_q.size(), WORDS);
        end
    endtask

    task automatic test_timeout();
        int unsigned t0;
        start_frame();
        send_bits(4, 1'b1, 1'b0, 1'b0);
        IM1 = 1'($urandom_range(0, 1)); IM0 = !IM1;
        tick(10);
        IM1 = 1'b0; IM0 = 1'b0;
        t0 = cyc;
        // Low accepted FILT+2 edges after this drive; the error lands TMO edges later.
        while (cyc < t0 + FILT + 1 + TMO) @(negedge clk);
        checks++;
        if (a_err !== 1'b0 || b_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tmo_early got lsb=%0b msb=%0b expected 0", a_err, b_err);
        end
        @(negedge clk);
        checks++;
        if ({a_err, a_code, b_err, b_code} !== 6'b111_111) begin
            failures++;
            $display("[TB] FAIL tmo_err got lsb=%0b/%b msb=%0b/%b expected 1/11", a_err, a_code, b_err, b_code);
        end
        tick(90);
        end_frame();
        checks++;
        if (a_data_q.size() != 0 || b_data_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL tmo_words got lsb=%0d msb=%0d expected 0", a_data_q.size(), b_data_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        int sa, sb;
        start_frame();
        send_bits(5, 1'b1, 1'b0, 1'b0);
        IM1 = 1'b1; IM0 = 1'b0;
        tick(4);
        nRST = 1'b0;
        sa = a_starts; sb = b_starts;
        @(negedge clk);
        checks++;
        if (a_all !== '0 || b_all !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got lsb=%h msb=%h expected 0", a_all, b_all);
        end
        nRST = 1'b1; IM1 = 1'b0;
        tick(15);
        checks++;
        if (a_starts != sa + 1 || b_starts != sb + 1 || a_data_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL midreset_idle got starts=%0d/%0d words=%0d expected 1/1 words 0",
                     a_starts - sa, b_starts - sb, a_data_q.size());
        end
        end_frame();
        start_frame();
        send_bits(64, 1'b1, 1'b1, 1'b0);
        end_frame();
        checks++;
        if (a_data_q.size() != WORDS || b_data_q.size() != WORDS || a_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_recover got words=%0d/%0d err=%0b expected %0d words err 0",
                     a_data_q.size(), b_data_q.size(), a_err, WORDS);
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                checks++;
                if (a_data_q[w] !== exp_word(w, 1'b0) || b_data_q[w] !== exp_word(w, 1'b1)) begin
                    failures++;
                    $display("[TB] FAIL midreset_word%0d got %h/%h expected %h/%h",
                             w, a_data_q[w], b_data_q[w], exp_word(w, 1'b0), exp_word(w, 1'b1));
                end
            end
        end
        checks++;
        if (pulse_viol != 0 || orphan_done != 0) begin
            failures++;
            $display("[TB] FAIL pulses got back_to_back=%0d orphan_done=%0d expected 0/0", pulse_viol, orphan_done);
        end
    endtask

    initial begin
        nRST = 1'b0; HO = 1'b0; IM1 = 1'b0; IM0 = 1'b0;
        test_reset();
        test_alternating();
        test_random_frames();
        test_glitches();
        test_both_high();
        test_short_frame();
        test_timeout();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
